fetch_stage: RTL and testbench

//  Instruction fetch front end feeding decode in the 4-register 8-bit CPU.

---
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, synchronous imem read issue, prefetch FIFO toward decode,
// and redirect handling for branches/jumps.
module fetch_stage #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned INSN_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_rd,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [INSN_W-1:0] insn,
  output logic [PC_W-1:0]   insn_pc,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } entry_t;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    infl_pc_q, infl_pc_d;
  logic               inflight_q, inflight_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  entry_t             fifo_q [DEPTH];
  entry_t             head;
  logic               credit_c, issue_c, push_c, pop_c;

  // Next-state: redirect overrides issue, push and pop in the same cycle.
  always_comb begin
    credit_c   = (SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(DEPTH);
    issue_c    = (state_q == RUN) && !redirect_valid && credit_c;
    push_c     = inflight_q && !redirect_valid;
    pop_c      = (count_q != '0) && insn_ready && !redirect_valid;

    state_d    = state_q;
    pc_d       = pc_q;
    infl_pc_d  = infl_pc_q;
    inflight_d = issue_c;
    count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (issue_c) begin
      pc_d      = pc_q + PC_W'(1);
      infl_pc_d = pc_q;
    end
    if (push_c)
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop_c)
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);

    if (redirect_valid) begin
      state_d  = FLUSH;
      pc_d     = redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= PC_W'(RESET_PC);
      infl_pc_q  <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      infl_pc_q  <= infl_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (push_c) begin
      fifo_q[wr_ptr_q] <= '{pc: infl_pc_q, insn: imem_rdata};
    end
  end

  assign head       = fifo_q[rd_ptr_q];
  assign imem_rd    = issue_c;
  assign imem_addr  = pc_q;
  assign insn_valid = (count_q != '0);
  assign insn       = head.insn;
  assign insn_pc    = head.pc;

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_c && !pop_c && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus with a scoreboard queue of expected {pc, insn}
// pairs drained by an independent monitor on every decode handshake.
module tb_fetch_stage;

  logic       clk;
  logic       rst_n;
  logic       imem_rd;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       insn_valid;
  logic       insn_ready;
  logic [7:0] insn;
  logic [7:0] insn_pc;
  logic       redirect_valid;
  logic [7:0] redirect_pc;

  logic [7:0]  imem [256];
  logic [15:0] exp_q [$];
  int          total;
  int          bad;

  fetch_stage #(.PC_W(8), .INSN_W(8), .DEPTH(4), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_rd        (imem_rd),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn           (insn),
    .insn_pc        (insn_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data one cycle after the read strobe.
  always @(posedge clk) if (imem_rd) imem_rdata <= imem[imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_stream(input logic [7:0] start, input int n);
    logic [7:0] p;
    for (int i = 0; i < n; i++) begin
      p = start + 8'(i);
      exp_q.push_back({p, p + 8'h10});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted instruction must match the next expected entry.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && insn_valid && insn_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_insn: got pc=%0h insn=%0h with nothing expected", insn_pc, insn);
      end else begin
        e = exp_q.pop_front();
        chk("insn_pc", 32'(insn_pc), 32'(e[15:8]));
        chk("insn", 32'(insn), 32'(e[7:0]));
      end
    end
  end

  // Release reset with insn_ready=1 and check boot timing; cycle 1 is the first cycle out of reset.
  task automatic boot_check(input string tag);
    exp_q.delete();
    push_stream(8'h00, 64);
    insn_ready = 1'b1;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_c1_rd"}, 32'(imem_rd), 32'd0);
    chk({tag, "_c1_valid"}, 32'(insn_valid), 32'd0);
    step(); @(negedge clk);
    chk({tag, "_c2_rd"}, 32'(imem_rd), 32'd1);
    chk({tag, "_c2_addr"}, 32'(imem_addr), 32'h00);
    step(); @(negedge clk);
    chk({tag, "_c3_rd"}, 32'(imem_rd), 32'd1);
    chk({tag, "_c3_addr"}, 32'(imem_addr), 32'h01);
    chk({tag, "_c3_valid"}, 32'(insn_valid), 32'd0);
    step(); @(negedge clk);
    chk({tag, "_c4_valid"}, 32'(insn_valid), 32'd1);
    for (int i = 0; i < 12; i++) begin
      step(); @(negedge clk);
      chk({tag, "_steady_valid"}, 32'(insn_valid), 32'd1);
      chk({tag, "_steady_rd"}, 32'(imem_rd), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd_cnt;
    total = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) imem[i] = 8'(i + 16);
    rst_n = 1'b0;
    insn_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    imem_rdata = 8'h00;
    repeat (3) step();

    @(negedge clk);
    chk("rst_rd", 32'(imem_rd), 32'd0);
    chk("rst_valid", 32'(insn_valid), 32'd0);
    chk("rst_insn", 32'(insn), 32'd0);
    chk("rst_insn_pc", 32'(insn_pc), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);

    // Test 1: boot timing and gap-free stream
    boot_check("t1");

    // Test 2: decode stalled from reset; exactly DEPTH reads, then in-order drain
    step();
    rst_n = 1'b0;
    insn_ready = 1'b0;
    exp_q.delete();
    push_stream(8'h00, 40);
    step();
    rst_n = 1'b1;
    rd_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (imem_rd) rd_cnt++;
      if (c < 10) step();
    end
    chk("t2_reads", 32'(rd_cnt), 32'd4);
    chk("t2_rd_idle", 32'(imem_rd), 32'd0);
    chk("t2_valid_full", 32'(insn_valid), 32'd1);
    step();
    insn_ready = 1'b1;
    repeat (8) step();
    chk("t2_drained8", 32'(exp_q.size()), 32'd32);

    // Test 3: redirect to 0x40 with entries buffered
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    chk("t3_r_rd", 32'(imem_rd), 32'd0);
    chk("t3_r_valid", 32'(insn_valid), 32'd1);
    step();
    redirect_valid = 1'b0;
    exp_q.delete();
    push_stream(8'h40, 32);
    @(negedge clk);
    chk("t3_r1_valid", 32'(insn_valid), 32'd0);
    chk("t3_r1_rd", 32'(imem_rd), 32'd0);
    step(); @(negedge clk);
    chk("t3_r2_valid", 32'(insn_valid), 32'd0);
    chk("t3_r2_rd", 32'(imem_rd), 32'd1);
    chk("t3_r2_addr", 32'(imem_addr), 32'h40);
    step(); @(negedge clk);
    chk("t3_r3_valid", 32'(insn_valid), 32'd0);
    chk("t3_r3_addr", 32'(imem_addr), 32'h41);
    step(); @(negedge clk);
    chk("t3_r4_valid", 32'(insn_valid), 32'd1);
    repeat (4) step();

    // Test 4: back-to-back redirects, only the second target survives
    redirect_valid = 1'b1;
    redirect_pc = 8'h20;
    @(negedge clk);
    chk("t4_r_rd", 32'(imem_rd), 32'd0);
    step();
    redirect_pc = 8'h30;
    @(negedge clk);
    chk("t4_r1_rd", 32'(imem_rd), 32'd0);
    chk("t4_r1_valid", 32'(insn_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    exp_q.delete();
    push_stream(8'h30, 32);
    @(negedge clk);
    chk("t4_r2_rd", 32'(imem_rd), 32'd0);
    chk("t4_r2_valid", 32'(insn_valid), 32'd0);
    step(); @(negedge clk);
    chk("t4_r3_rd", 32'(imem_rd), 32'd1);
    chk("t4_r3_addr", 32'(imem_addr), 32'h30);
    step(); @(negedge clk);
    chk("t4_r4_valid", 32'(insn_valid), 32'd0);
    step(); @(negedge clk);
    chk("t4_r5_valid", 32'(insn_valid), 32'd1);
    repeat (4) step();

    // Test 5: PC wrap 0xFE -> 0x01
    redirect_valid = 1'b1;
    redirect_pc = 8'hFE;
    step();
    redirect_valid = 1'b0;
    exp_q.delete();
    push_stream(8'hFE, 8);
    repeat (7) step();
    chk("t5_consumed", 32'(exp_q.size()), 32'd4);

    // Test 6: asynchronous reset mid-stream with a non-empty FIFO
    insn_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rd_drop", 32'(imem_rd), 32'd0);
    chk("t6_valid_drop", 32'(insn_valid), 32'd0);
    chk("t6_insn_zero", 32'(insn), 32'd0);
    chk("t6_pc_zero", 32'(insn_pc), 32'd0);
    chk("t6_addr_reset", 32'(imem_addr), 32'd0);
    step();
    boot_check("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
